// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bus levels and R/W encoding.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_READ  = 1'b1;

  // Open-drain: the only way to put a level on SDA is to pull it low.
  function automatic logic oe_for(logic level);
    return (level == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_d;
  logic                   sda_d;

  // Preset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_i};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_i};
      scl_d  <= scl_ff[SYNC_STAGES-1];
      sda_d  <= sda_ff[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target serving a small byte register bank; writes auto-increment the pointer,
// reads stream bank contents, SDA is driven only through an open-drain enable.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h42,
  parameter int         NREG        = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  output logic [NREG*8-1:0]       regs,
  output logic                    wr_pulse,
  output logic [$clog2(NREG)-1:0] wr_index,
  output logic                    busy
);

  localparam int PW = $clog2(NREG);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic rise_evt, fall_evt;

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shift, shift_n;
  logic [7:0]        rd_byte, rd_byte_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic              byte_full, byte_full_n;
  logic              ack_phase, ack_phase_n;
  logic              busy_n, sda_oe_n, wr_pulse_n;
  logic [PW-1:0]     wr_index_n;
  logic [NREG*8-1:0] regs_n;
  logic [7:0]        cur_reg;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .res       (res),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rise_evt = scl_rise & scl_s;
  assign fall_evt = scl_fall & ~scl_s;
  assign cur_reg  = regs[{ptr, 3'b000} +: 8];

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      rd_byte   <= '0;
      ptr       <= '0;
      byte_full <= 1'b0;
      ack_phase <= 1'b0;
      busy      <= 1'b0;
      sda_oe    <= 1'b0;
      regs      <= '0;
      wr_pulse  <= 1'b0;
      wr_index  <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      rd_byte   <= rd_byte_n;
      ptr       <= ptr_n;
      byte_full <= byte_full_n;
      ack_phase <= ack_phase_n;
      busy      <= busy_n;
      sda_oe    <= sda_oe_n;
      regs      <= regs_n;
      wr_pulse  <= wr_pulse_n;
      wr_index  <= wr_index_n;
    end
  end

  // byte_full marks "8 bits clocked in/out, act on the next SCL fall".
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rd_byte_n   = rd_byte;
    ptr_n       = ptr;
    byte_full_n = byte_full;
    ack_phase_n = ack_phase;
    busy_n      = busy;
    sda_oe_n    = sda_oe;
    regs_n      = regs;
    wr_pulse_n  = 1'b0;
    wr_index_n  = wr_index;

    if (start_det) begin
      state_n     = ST_ADDR;
      bit_cnt_n   = '0;
      byte_full_n = 1'b0;
      ack_phase_n = 1'b0;
      sda_oe_n    = 1'b0;
    end else if (stop_det) begin
      state_n     = ST_IDLE;
      busy_n      = 1'b0;
      sda_oe_n    = 1'b0;
      byte_full_n = 1'b0;
      ack_phase_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WR_DATA: begin
          if (rise_evt && !ack_phase) begin
            shift_n     = {shift[6:0], sda_s};
            bit_cnt_n   = bit_cnt + 3'd1;
            byte_full_n = (bit_cnt == 3'd7);
          end else if (fall_evt && ack_phase) begin
            ack_phase_n = 1'b0;
            sda_oe_n    = 1'b0;
            state_n     = ST_WR_DATA;
          end else if (fall_evt && byte_full) begin
            byte_full_n = 1'b0;
            if (state == ST_ADDR) begin
              if (shift[7:1] == TGT_ADDR) begin
                busy_n   = 1'b1;
                sda_oe_n = oe_for(I2C_ACK);
                state_n  = ST_ADDR_ACK;
              end else begin
                state_n  = ST_IGNORE;
              end
            end else begin
              ack_phase_n = 1'b1;
              sda_oe_n    = oe_for(I2C_ACK);
              if (state == ST_PTR) begin
                ptr_n = shift[PW-1:0];
              end else begin
                regs_n[{ptr, 3'b000} +: 8] = shift;
                wr_pulse_n = 1'b1;
                wr_index_n = ptr;
                ptr_n      = ptr + PW'(1);
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (fall_evt) begin
            bit_cnt_n = '0;
            if (shift[0] == RW_READ) begin
              state_n   = ST_RD_DATA;
              rd_byte_n = cur_reg;
              sda_oe_n  = oe_for(cur_reg[7]);
            end else begin
              state_n   = ST_PTR;
              sda_oe_n  = 1'b0;
            end
          end
        end
        ST_RD_DATA: begin
          if (rise_evt) begin
            bit_cnt_n   = bit_cnt + 3'd1;
            byte_full_n = (bit_cnt == 3'd7);
          end else if (fall_evt) begin
            if (byte_full) begin
              byte_full_n = 1'b0;
              sda_oe_n    = 1'b0;
              state_n     = ST_RD_ACK;
            end else begin
              sda_oe_n = oe_for(rd_byte[3'd7 - bit_cnt]);
            end
          end
        end
        ST_RD_ACK: begin
          if (rise_evt) begin
            if (sda_s == I2C_NACK) begin
              state_n = ST_IGNORE;
            end else begin
              ptr_n       = ptr + PW'(1);
              byte_full_n = 1'b1;
            end
          end else if (fall_evt && byte_full) begin
            byte_full_n = 1'b0;
            bit_cnt_n   = '0;
            state_n     = ST_RD_DATA;
            rd_byte_n   = cur_reg;
            sda_oe_n    = oe_for(cur_reg[7]);
          end
        end
        default: begin
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bus-level bench: a bit-banged I2C controller drives the target while scoreboard
// monitors compare each SCL-rise SDA drive and every register write strobe.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 5;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } wr_t;

  logic        clk;
  logic        res;
  logic        scl_i;
  logic        sda_ctrl;
  logic        sda_i;
  logic        sda_oe;
  logic [31:0] regs;
  logic        wr_pulse;
  logic [1:0]  wr_index;
  logic        busy;

  wr_t  wr_q[$];
  logic bit_q[$];
  logic bit_phase = 1'b0;
  int   checks = 0;
  int   passes = 0;

  assign sda_i = sda_ctrl & ~sda_oe;

  i2c_target_regs dut (
    .clk      (clk),
    .res      (res),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_oe   (sda_oe),
    .regs     (regs),
    .wr_pulse (wr_pulse),
    .wr_index (wr_index),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic exp_oe);
    sda_ctrl = b;
    bit_q.push_back(exp_oe);
    wait_clk(Q);
    bit_phase = 1'b1;
    scl_i = 1'b1;
    wait_clk(2 * Q);
    scl_i = 1'b0;
    bit_phase = 1'b0;
    wait_clk(Q);
  endtask

  // Controller-to-target byte followed by the ACK clock with SDA released.
  task automatic applyStimulus(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
    send_bit(1'b1, exp_ack);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic ctrl_bit);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, ~exp[i]);
    send_bit(ctrl_bit, 1'b0);
  endtask

  task automatic i2c_start();
    if (scl_i == 1'b0) begin
      sda_ctrl = 1'b1;
      wait_clk(Q);
      scl_i = 1'b1;
      wait_clk(Q);
    end
    sda_ctrl = 1'b0;
    wait_clk(2 * Q);
    scl_i = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0;
    wait_clk(Q);
    scl_i = 1'b1;
    wait_clk(Q);
    sda_ctrl = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_sda_oe"},   sda_oe,   0);
    checkOutput({tag, "_regs"},     regs,     0);
    checkOutput({tag, "_wr_pulse"}, wr_pulse, 0);
    checkOutput({tag, "_wr_index"}, wr_index, 0);
    checkOutput({tag, "_busy"},     busy,     0);
  endtask

  // SDA drive seen by the controller at each data/ACK clock rise.
  initial begin
    logic e;
    forever begin
      @(posedge scl_i);
      if (bit_phase && bit_q.size() > 0) begin
        e = bit_q.pop_front();
        checkOutput("sda_oe_bit", sda_oe, e);
      end
    end
  end

  // Every write strobe must match the next expected register write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (res && wr_pulse) begin
        if (wr_q.size() == 0) begin
          checkOutput("wr_unexpected", wr_pulse, 0);
        end else begin
          w = wr_q.pop_front();
          checkOutput("wr_index", wr_index, w.idx);
          checkOutput("wr_data", regs[w.idx*8 +: 8], w.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res = 1'b1;
    scl_i = 1'b1;
    sda_ctrl = 1'b1;
    #2 res = 1'b0;
    wait_clk(3);
    check_reset_state("reset");
    res = 1'b1;
    wait_clk(5);

    $display("[TB] write sequence");
    i2c_start();
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h01, 1'b1);
    wr_q.push_back('{1, 8'hAA});
    applyStimulus(8'hAA, 1'b1);
    wr_q.push_back('{2, 8'h55});
    applyStimulus(8'h55, 1'b1);
    checkOutput("busy_during_write", busy, 1);
    i2c_stop();
    checkOutput("busy_after_stop", busy, 0);
    checkOutput("regs_after_write", regs, 32'h0055AA00);

    $display("[TB] pointer wrap");
    i2c_start();
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h03, 1'b1);
    wr_q.push_back('{3, 8'h11});
    applyStimulus(8'h11, 1'b1);
    wr_q.push_back('{0, 8'h22});
    applyStimulus(8'h22, 1'b1);
    i2c_stop();
    checkOutput("regs_after_wrap", regs, 32'h1155AA22);

    $display("[TB] combined read");
    i2c_start();
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h01, 1'b1);
    i2c_start();
    applyStimulus(8'h85, 1'b1);
    checkOutput("busy_during_read", busy, 1);
    read_byte(8'hAA, I2C_ACK);
    read_byte(8'h55, I2C_NACK);
    wait_clk(Q);
    checkOutput("no_drive_after_nack", sda_oe, 0);
    i2c_stop();
    checkOutput("busy_after_read", busy, 0);

    // Pointer must still be 2 since the NACKed byte does not advance it.
    i2c_start();
    applyStimulus(8'h85, 1'b1);
    read_byte(8'h55, I2C_NACK);
    i2c_stop();

    $display("[TB] address mismatch");
    i2c_start();
    applyStimulus(8'h86, 1'b0);
    checkOutput("busy_mismatch", busy, 0);
    applyStimulus(8'h00, 1'b0);
    i2c_stop();
    checkOutput("regs_after_mismatch", regs, 32'h1155AA22);
    checkOutput("busy_after_mismatch", busy, 0);

    $display("[TB] abort mid-byte");
    i2c_start();
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h02, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i2c_stop();
    checkOutput("regs_after_abort", regs, 32'h1155AA22);
    checkOutput("busy_after_abort", busy, 0);
    checkOutput("sda_oe_after_abort", sda_oe, 0);
    i2c_start();
    applyStimulus(8'h84, 1'b1);
    applyStimulus(8'h02, 1'b1);
    wr_q.push_back('{2, 8'h77});
    applyStimulus(8'h77, 1'b1);
    i2c_stop();
    checkOutput("regs_after_recovery", regs, 32'h1177AA22);

    $display("[TB] reset during ACK");
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h84 >> i) & 8'h01) != 0, 1'b0);
    sda_ctrl = 1'b1;
    checkOutput("ack_before_reset", sda_oe, 1);
    #1 res = 1'b0;
    #1;
    checkOutput("async_release_sda_oe", sda_oe, 0);
    checkOutput("async_clear_regs", regs, 0);
    checkOutput("async_clear_busy", busy, 0);
    scl_i = 1'b1;
    sda_ctrl = 1'b1;
    wait_clk(3);
    res = 1'b1;
    wait_clk(5);
    check_reset_state("post_reset");

    checkOutput("wr_queue_drained", wr_q.size(), 0);
    checkOutput("bit_queue_drained", bit_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
